// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stalls, squashes, memory-wait freezes, halt drain and memory timeout.
// Stage controls are combinational (zero latency); PIPELINE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipeline_ctrl #(
    parameter int REG_W        = 3,
    parameter int MEM_TIMEOUT  = 15,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_halt,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    localparam logic [7:0] TIMEOUT_V  = 8'(MEM_TIMEOUT);
    localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic freeze, lu;
    logic [7:0] wait_inc;
    logic pc_w_c, if_id_w_c, id_ex_w_c, ex_mem_w_c;
    logic if_id_f_c, id_ex_f_c, mem_wb_f_c;
    logic stall_ev, flush_ev;

    assign freeze   = mem_req & ~mem_ready;
    assign lu       = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                      ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    assign wait_inc = wait_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        mem_err_d   = mem_err_q;
        pc_w_c      = 1'b1;
        if_id_w_c   = 1'b1;
        id_ex_w_c   = 1'b1;
        ex_mem_w_c  = 1'b1;
        if_id_f_c   = 1'b0;
        id_ex_f_c   = 1'b0;
        mem_wb_f_c  = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    {pc_w_c, if_id_w_c, id_ex_w_c, ex_mem_w_c} = 4'b0000;
                    mem_wb_f_c = 1'b1;
                    stall_ev   = 1'b1;
                    wait_cnt_d = 8'd1;
                    if (TIMEOUT_V <= 8'd1) begin
                        mem_err_d = 1'b1;
                        state_d   = HALTED;
                    end else begin
                        state_d   = MEM_WAIT;
                    end
                end else if (branch_taken) begin
                    if_id_f_c = 1'b1;
                    id_ex_f_c = 1'b1;
                    flush_ev  = 1'b1;
                end else if (lu) begin
                    pc_w_c    = 1'b0;
                    if_id_w_c = 1'b0;
                    id_ex_f_c = 1'b1;
                    stall_ev  = 1'b1;
                end else if (id_halt) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    {pc_w_c, if_id_w_c, id_ex_w_c, ex_mem_w_c} = 4'b0000;
                    mem_wb_f_c = 1'b1;
                    stall_ev   = 1'b1;
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= TIMEOUT_V) begin
                        mem_err_d = 1'b1;
                        state_d   = HALTED;
                    end
                end
            end
            DRAIN: begin
                // ID only holds post-halt instructions being flushed, so lu and branches are moot here.
                if (freeze) begin
                    {pc_w_c, if_id_w_c, id_ex_w_c, ex_mem_w_c} = 4'b0000;
                    mem_wb_f_c = 1'b1;
                    stall_ev   = 1'b1;
                end else begin
                    pc_w_c    = 1'b0;
                    if_id_f_c = 1'b1;
                    if (drain_cnt_q == 2'd0) begin
                        state_d = HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 2'd1;
                    end
                end
            end
            default: begin
                {pc_w_c, if_id_w_c, id_ex_w_c, ex_mem_w_c} = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            drain_cnt_q <= 2'd0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Controls are forced inactive while reset is held so nothing advances.
    assign pc_write     = pc_w_c     & ~reset;
    assign if_id_write  = if_id_w_c  & ~reset;
    assign id_ex_write  = id_ex_w_c  & ~reset;
    assign ex_mem_write = ex_mem_w_c & ~reset;
    assign if_id_flush  = if_id_f_c  & ~reset;
    assign id_ex_flush  = id_ex_f_c  & ~reset;
    assign mem_wb_flush = mem_wb_f_c & ~reset;
    assign halted       = (state_q == HALTED);
    assign mem_err      = mem_err_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    logic perf_unused;
    assign perf_unused = stall_ev | flush_ev;
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + randomized bench for pipeline_ctrl against a cycle-count reference model.
module tb_pipeline_ctrl;
    localparam int REG_W        = 3;
    localparam int MEM_TIMEOUT  = 15;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 16;

    logic             clk, reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_use_rs, id_use_rt, id_halt;
    logic             ex_mem_read, ex_reg_write, branch_taken, mem_req, mem_ready;
    logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic             if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [8:0]       obs_v;

    int checks = 0;
    int errors = 0;

    // Reference model: mode flags plus plain cycle counts.
    bit m_halted, m_waiting, m_err;
    int m_wait_len, m_drain_left, m_stalls, m_flushes;

    pipeline_ctrl #(
        .REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .halted(halted), .mem_err(mem_err),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    assign obs_v = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                    if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag, input int st, input int fl);
`ifdef PIPELINE_CTRL_PERF_EN
        check({tag, "_stall_cnt"}, 32'(stall_count), 32'(st));
        check({tag, "_flush_cnt"}, 32'(flush_count), 32'(fl));
`else
        check({tag, "_stall_cnt"}, 32'(stall_count), 32'(st - st));
        check({tag, "_flush_cnt"}, 32'(flush_count), 32'(fl - fl));
`endif
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_use_rs = 0; id_use_rt = 0; id_halt = 0;
        ex_mem_read = 0; ex_reg_write = 0; branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic model_clear();
        m_halted = 0; m_waiting = 0; m_err = 0;
        m_wait_len = 0; m_drain_left = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // Outputs must be inactive while reset is held; model restarts in RUN.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_outs"}, 32'(obs_v), 32'd0);
        check_counters(tag, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic do_cycle(input string tag);
        bit lu, fr, exp_halt, exp_err;
        logic [3:0] en;
        logic [2:0] fl;
        int exp_st, exp_fl;
        @(negedge clk);
        lu = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        fr = mem_req && !mem_ready;
        en = 4'b1111; fl = 3'b000;
        exp_halt = m_halted; exp_err = m_err;
        exp_st = m_stalls; exp_fl = m_flushes;
        if (m_halted) begin
            en = 4'b0000;
        end else if (m_waiting) begin
            if (mem_ready) begin
                m_waiting = 0;
            end else begin
                en = 4'b0000; fl = 3'b001; m_stalls++; m_wait_len++;
                if (m_wait_len >= MEM_TIMEOUT) begin
                    m_err = 1; m_halted = 1; m_waiting = 0;
                end
            end
        end else if (m_drain_left > 0) begin
            if (fr) begin
                en = 4'b0000; fl = 3'b001; m_stalls++;
            end else begin
                en = 4'b0111; fl = 3'b100; m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end
        end else begin
            if (fr) begin
                en = 4'b0000; fl = 3'b001; m_stalls++; m_wait_len = 1;
                if (m_wait_len >= MEM_TIMEOUT) begin
                    m_err = 1; m_halted = 1;
                end else begin
                    m_waiting = 1;
                end
            end else if (branch_taken) begin
                fl = 3'b110; m_flushes++;
            end else if (lu) begin
                en = 4'b0011; fl = 3'b010; m_stalls++;
            end else if (id_halt) begin
                m_drain_left = DRAIN_CYCLES;
            end
        end
        check(tag, 32'(obs_v), 32'({en, fl, exp_halt, exp_err}));
        check_counters(tag, exp_st, exp_fl);
        @(posedge clk); #1;
    endtask

    task automatic set_lu(input logic [REG_W-1:0] rd);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = rd; id_use_rs = 1; id_rs = 3'd3;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        model_clear();
        do_reset("reset");
        do_cycle("idle");

        set_lu(3'd3);  do_cycle("lu_stall");
        clr();         do_cycle("lu_after");
        set_lu(3'd0);  do_cycle("lu_rd0");
        clr();         do_cycle("lu_rd0_after");

        set_lu(3'd3); branch_taken = 1; do_cycle("branch_lu");
        clr();                          do_cycle("branch_after");

        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) do_cycle("mem_wait");
        mem_ready = 1; do_cycle("mem_resume");
        clr();         do_cycle("mem_after");

        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < MEM_TIMEOUT + 3; i++) do_cycle("timeout");
        clr(); mem_ready = 1; do_cycle("timeout_sticky");
        do_reset("reset_after_timeout");

        id_halt = 1; do_cycle("halt_take");
        clr();       do_cycle("drain1");
        mem_req = 1; do_cycle("drain_freeze");
        clr();       do_cycle("drain2");
        do_cycle("drain3");
        do_cycle("halted");
        do_reset("reset_after_halt");

        id_halt = 1; branch_taken = 1; do_cycle("halt_branch");
        clr();                         do_cycle("halt_branch_after");
        id_halt = 1; set_lu(3'd3);     do_cycle("halt_lu_stall");
        clr(); id_halt = 1;            do_cycle("halt_retake");
        clr();                         do_cycle("drain_pre_reset");

        reset = 1'b1;
        #1;
        check("mid_drain_reset_outs", 32'(obs_v), 32'd0);
        check_counters("mid_drain_reset", 0, 0);
        #1 reset = 1'b0;
        model_clear();
        do_cycle("run_after_reset");

        for (int i = 0; i < 800; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) begin
                clr();
                do_reset("rand_reset");
            end else begin
                id_rs        = 3'($urandom_range(0, 3));
                id_rt        = 3'($urandom_range(0, 3));
                ex_rd        = 3'($urandom_range(0, 3));
                id_use_rs    = 1'($urandom_range(0, 1));
                id_use_rt    = 1'($urandom_range(0, 1));
                ex_mem_read  = 1'($urandom_range(0, 1));
                ex_reg_write = ($urandom_range(0, 3) != 0);
                branch_taken = ($urandom_range(0, 5) == 0);
                id_halt      = ($urandom_range(0, 19) == 0);
                mem_req      = ($urandom_range(0, 5) == 0);
                if (i >= 400 && i < 500) mem_ready = ($urandom_range(0, 15) == 0);
                else                     mem_ready = ($urandom_range(0, 3) != 0);
                do_cycle("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
